// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and defaults.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  localparam int unsigned DEFAULT_SETTLE = 1;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-window timer: cleared by load, advances while count is high, and
// flags the cycle on which the SETTLE-th counting cycle is reached.
module tt_settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int unsigned W = $clog2(SETTLE + 1);
  localparam logic [W-1:0] LAST = W'(SETTLE - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  assign expire = count && (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked exhaustive sweep of an N_IN-bit input space, comparing two
// implementations per vector and recording mismatch count and first bad vector.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = DEFAULT_SETTLE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [N_IN-1:0]   vec,
  input  logic [N_OUT-1:0]  out_a,
  input  logic [N_OUT-1:0]  out_b,
  output logic              sample_vld,
  output logic              sample_match,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   first_bad,
  output logic              first_bad_vld
);

  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE = (N_IN + 1)'(1);

  tt_state_e         state_q;
  logic [N_IN-1:0]   vec_q;
  logic [N_IN:0]     mismatch_cnt_q;
  logic [N_IN-1:0]   first_bad_q;
  logic              first_bad_vld_q;

  logic              start_ok;
  logic              in_sample;
  logic              match;
  logic              timer_expire;

  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
  assign in_sample = (state_q == SAMPLE);
  assign match     = (out_a == out_b);

  // Counter restarts both when a sweep is accepted and when leaving SAMPLE.
  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (start_ok || in_sample),
    .count  (state_q == APPLY),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      vec_q           <= '0;
      mismatch_cnt_q  <= '0;
      first_bad_q     <= '0;
      first_bad_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q         <= APPLY;
            vec_q           <= '0;
            mismatch_cnt_q  <= '0;
            first_bad_q     <= '0;
            first_bad_vld_q <= 1'b0;
          end
        end
        APPLY: begin
          if (timer_expire) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (!match) begin
            mismatch_cnt_q <= mismatch_cnt_q + CNT_ONE;
            if (!first_bad_vld_q) begin
              first_bad_q     <= vec_q;
              first_bad_vld_q <= 1'b1;
            end
          end
          // Sweep ends at all-ones; vec holds its final value in DONE.
          if (vec_q == '1) begin
            state_q <= DONE;
          end else begin
            vec_q   <= vec_q + VEC_ONE;
            state_q <= APPLY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec           = vec_q;
  assign sample_vld    = in_sample;
  assign sample_match  = in_sample && match;
  assign busy          = (state_q == APPLY) || (state_q == SAMPLE);
  assign done          = (state_q == DONE);
  assign pass          = (state_q == DONE) && (mismatch_cnt_q == '0);
  assign mismatch_cnt  = mismatch_cnt_q;
  assign first_bad     = first_bad_q;
  assign first_bad_vld = first_bad_vld_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3)
// driving small 2-input gate expressions back into the comparator.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance with SETTLE=1.
  logic       reset, start, mode;
  logic [1:0] vec;
  logic [0:0] out_a, out_b;
  logic       sample_vld, sample_match, busy, done, pass, first_bad_vld;
  logic [2:0] mismatch_cnt;
  logic [1:0] first_bad;

  // mode=0: A = x|~y, B = x&~y (mismatch at 00, 11); mode=1: both x&~y.
  assign out_a = mode ? (vec[1] & ~vec[0]) : (vec[1] | ~vec[0]);
  assign out_b = vec[1] & ~vec[0];

  truth_table_sweeper #(
    .N_IN   (2),
    .N_OUT  (1),
    .SETTLE (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .vec           (vec),
    .out_a         (out_a),
    .out_b         (out_b),
    .sample_vld    (sample_vld),
    .sample_match  (sample_match),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .mismatch_cnt  (mismatch_cnt),
    .first_bad     (first_bad),
    .first_bad_vld (first_bad_vld)
  );

  // Instance with SETTLE=3, both implementations identical.
  logic       start3;
  logic [1:0] vec3;
  logic [0:0] out3;
  logic       sample_vld3, sample_match3, busy3, done3, pass3, first_bad_vld3;
  logic [2:0] mismatch_cnt3;
  logic [1:0] first_bad3;

  assign out3 = vec3[1] & ~vec3[0];

  truth_table_sweeper #(
    .N_IN   (2),
    .N_OUT  (1),
    .SETTLE (3)
  ) dut3 (
    .clk           (clk),
    .reset         (reset),
    .start         (start3),
    .vec           (vec3),
    .out_a         (out3),
    .out_b         (out3),
    .sample_vld    (sample_vld3),
    .sample_match  (sample_match3),
    .busy          (busy3),
    .done          (done3),
    .pass          (pass3),
    .mismatch_cnt  (mismatch_cnt3),
    .first_bad     (first_bad3),
    .first_bad_vld (first_bad_vld3)
  );

  // Strobe log and busy/done exclusivity monitor, sampled mid-cycle.
  logic [1:0] sv_vec[$];
  logic       sv_match[$];
  int         excl_bad = 0;

  always @(negedge clk) begin
    if (sample_vld) begin
      sv_vec.push_back(vec);
      sv_match.push_back(sample_match);
    end
    if ((busy && done) || (busy3 && done3)) excl_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start, then count edges after the accepting edge until done.
  // poke_at > 0 re-asserts start so it is sampled on edge poke_at+1.
  task automatic run_sweep(input int poke_at, output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clk);
      cycles++;
      #1 start = (cycles == poke_at);
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic check_sweep1(input string tag, input int cycles);
    check({tag, "_cycles"}, cycles, 8);
    check({tag, "_cnt"}, mismatch_cnt, 3'd2);
    check({tag, "_first_bad"}, first_bad, 2'b00);
    check({tag, "_first_vld"}, first_bad_vld, 1'b1);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_strobes"}, sv_vec.size(), 4);
    for (int i = 0; i < 4 && i < sv_vec.size(); i++) begin
      check($sformatf("%s_vec%0d", tag, i), sv_vec[i], i);
      check($sformatf("%s_match%0d", tag, i), sv_match[i], (i == 1 || i == 2) ? 1 : 0);
    end
  endtask

  int cyc;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    mode   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    check("rst_vec", vec, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_cnt", mismatch_cnt, 3'd0);
    check("rst_first_vld", first_bad_vld, 1'b0);
    check("rst_sample_vld", sample_vld, 1'b0);

    // Scenario 1: mismatching implementations.
    sv_vec.delete(); sv_match.delete();
    run_sweep(0, cyc);
    check_sweep1("s1", cyc);

    // Scenario 6: restart from DONE with matching implementations.
    mode = 1'b1;
    sv_vec.delete(); sv_match.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("s6_done_drop", done, 1'b0);
    check("s6_busy", busy, 1'b1);
    check("s6_cnt_clr", mismatch_cnt, 3'd0);
    check("s6_first_clr", first_bad_vld, 1'b0);
    cyc = 0;
    while (cyc < 200 && !done) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check("s6_cycles", cyc, 8);
    check("s6_pass", pass, 1'b1);

    // Scenario 2: matching sweep, strobes for every vector.
    sv_vec.delete(); sv_match.delete();
    run_sweep(0, cyc);
    check("s2_cycles", cyc, 8);
    check("s2_cnt", mismatch_cnt, 3'd0);
    check("s2_first_vld", first_bad_vld, 1'b0);
    check("s2_pass", pass, 1'b1);
    check("s2_strobes", sv_vec.size(), 4);
    for (int i = 0; i < 4 && i < sv_vec.size(); i++) begin
      check($sformatf("s2_vec%0d", i), sv_vec[i], i);
      check($sformatf("s2_match%0d", i), sv_match[i], 1'b1);
    end

    // Scenario 4: start re-pulsed mid-sweep is ignored.
    mode = 1'b0;
    sv_vec.delete(); sv_match.delete();
    run_sweep(2, cyc);
    check_sweep1("s4", cyc);

    // Scenario 5: reset (together with start) at cycle 5 of a sweep.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("s5_pre_busy", busy, 1'b1);
    check("s5_pre_cnt", mismatch_cnt, 3'd1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("s5_vec", vec, 2'b00);
    check("s5_cnt", mismatch_cnt, 3'd0);
    check("s5_busy", busy, 1'b0);
    check("s5_done", done, 1'b0);
    check("s5_first_vld", first_bad_vld, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1 check("s5_idle_busy", busy, 1'b0);
    sv_vec.delete(); sv_match.delete();
    run_sweep(0, cyc);
    check_sweep1("s5r", cyc);

    // Scenario 3: SETTLE=3, each vector held 4 cycles, done at 16.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("s3_vec_c%0d", k), vec3, k / 4);
      check($sformatf("s3_done_c%0d", k), done3, 1'b0);
      @(posedge clk);
      #1;
    end
    check("s3_done16", done3, 1'b1);
    check("s3_vec_hold", vec3, 2'b11);
    check("s3_pass", pass3, 1'b1);
    check("s3_cnt", mismatch_cnt3, 3'd0);

    check("busy_done_excl", excl_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound in case a wait above never completes.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
